// File: rtl/u_seqdiv16_8_pkg.sv
// u_seqdiv_pkg: shared state encoding, default width and counter sizing for the sequential divider
package u_seqdiv_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int DEF_N = 8;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/u_seqdiv16_8_div_step.sv
// u_div_step: one combinational restoring step (trial subtract, keep on non-negative)
module u_div_step
    import u_seqdiv_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N:0]   t,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_next,
    output logic         q_bit
);
    logic [N+1:0] d;
    // borrow out of the widened subtraction marks a negative trial difference
    always_comb begin
        d      = {1'b0, t} - {2'b00, divisor};
        q_bit  = ~d[N+1];
        r_next = q_bit ? d[N:0] : t;
    end
endmodule

// File: rtl/u_seqdiv16_8.sv
// u_seqdiv16_8: sequential 2N/N unsigned restoring divider with valid/ready handshakes
module u_seqdiv16_8
    import u_seqdiv_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           overflow,
    output logic           div_by_zero
);
    localparam int CW = cnt_w(N);
    state_t        state;
    logic [N-1:0]  dvs;
    logic [N:0]    r;
    logic [N-1:0]  lo;
    logic [CW-1:0] cnt;
    logic [N:0]    r_next;
    logic          q_bit;
    u_div_step #(.N(N)) u_step (
        .t       ({r[N-1:0], lo[N-1]}),
        .divisor (dvs),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );
    // control FSM; the quotient output doubles as the quotient shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            dvs         <= '0;
            r           <= '0;
            lo          <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        dvs      <= divisor;
                        if (divisor == '0 || dividend[2*N-1:N] >= divisor) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            overflow    <= 1'b1;
                            div_by_zero <= (divisor == '0);
                        end else begin
                            state       <= BUSY;
                            r           <= {1'b0, dividend[2*N-1:N]};
                            lo          <= dividend[N-1:0];
                            cnt         <= CW'(N - 1);
                            quotient    <= '0;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b0;
                        end
                    end else in_ready <= 1'b1;
                end
                BUSY: begin
                    r        <= r_next;
                    lo       <= {lo[N-2:0], 1'b0};
                    quotient <= {quotient[N-2:0], q_bit};
                    cnt      <= cnt - 1'b1;
                    if (cnt == '0) begin
                        remainder <= r_next[N-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_u_seqdiv16_8.sv
// tb_u_seqdiv16_8: vector table, handshake corner cases and randomized checks against an arithmetic model
module tb_u_seqdiv16_8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  quotient, remainder;
    logic        overflow, div_by_zero;
    int checks = 0;
    int failures = 0;

    u_seqdiv16_8 #(.N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ov;
        logic        dz;
        int          lat;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // waits (bounded) for out_valid; lat counts sampled cycles from the accept cycle
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // issues one operation from a negedge and returns the result after completing the out handshake
    task automatic run(input logic [15:0] dd, input logic [7:0] dv,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic ov, output logic dz, output int lat);
        int n;
        n = 0;
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        wait_valid(lat);
        q  = quotient;
        r  = remainder;
        ov = overflow;
        dz = div_by_zero;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] q, r, q0, r0;
        logic ov, dz, ov0, dz0;
        int lat;
        vecs[0] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
        vecs[1] = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 9};
        vecs[2] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9};
        vecs[3] = '{16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1};
        vecs[4] = '{16'h0800, 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0, 1};
        vecs[5] = '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 9};
        vecs[6] = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 9};
        vecs[7] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
        vecs[8] = '{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1};
        vecs[9] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1};

        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_outputs", int'({quotient, remainder, overflow, div_by_zero}), 0);

        foreach (vecs[i]) begin
            run(vecs[i].dd, vecs[i].dv, q, r, ov, dz, lat);
            chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].q));
            chk($sformatf("vec%0d_r", i), int'(r), int'(vecs[i].r));
            chk($sformatf("vec%0d_ov", i), int'(ov), int'(vecs[i].ov));
            chk($sformatf("vec%0d_dz", i), int'(dz), int'(vecs[i].dz));
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_drop", i), int'({out_valid, in_ready}), 1);
        end

        // backpressure: result held while new operands wait at the input
        in_valid = 1'b1;
        dividend = 16'h03E8;
        divisor  = 8'h07;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'h0064;
        divisor  = 8'h0A;
        wait_valid(lat);
        chk("bp_lat", lat, 9);
        q0 = quotient;
        r0 = remainder;
        ov0 = overflow;
        dz0 = div_by_zero;
        chk("bp_q", int'(q0), 8'h8E);
        chk("bp_r", int'(r0), 8'h06);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_ready", int'(in_ready), 0);
            chk("bp_hold_data", int'({quotient, remainder, overflow, div_by_zero}), int'({q0, r0, ov0, dz0}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release", int'({out_valid, in_ready}), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_reaccept", int'(in_ready), 0);
        wait_valid(lat);
        chk("bp_next_q", int'(quotient), 8'h0A);
        chk("bp_next_r", int'(remainder), 8'h00);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // reset during the fourth step aborts the division
        in_valid = 1'b1;
        dividend = 16'h03E8;
        divisor  = 8'h07;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", int'({in_ready, out_valid, quotient, remainder, overflow, div_by_zero}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run(16'h0064, 8'h0A, q, r, ov, dz, lat);
        chk("abort_fresh_q", int'(q), 8'h0A);
        chk("abort_fresh_r", int'(r), 8'h00);
        chk("abort_fresh_ov", int'(ov), 0);

        // randomized operands against plain arithmetic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] dd;
            logic [7:0]  dv;
            int qf, rf, eov;
            dd = 16'($urandom);
            dv = 8'($urandom);
            if (i % 4 != 0 && dv != 0 && dd[15:8] >= dv) dd[15:8] = dd[15:8] % dv;
            qf  = (dv != 0) ? int'(dd) / int'(dv) : 0;
            rf  = (dv != 0) ? int'(dd) % int'(dv) : 0;
            eov = (dv == 0 || qf > 255) ? 1 : 0;
            run(dd, dv, q, r, ov, dz, lat);
            chk("rnd_q", int'(q), eov ? 255 : qf);
            chk("rnd_r", int'(r), eov ? 0 : rf);
            chk("rnd_ov", int'(ov), eov);
            chk("rnd_dz", int'(dz), (dv == 0) ? 1 : 0);
            chk("rnd_lat", lat, eov ? 1 : 9);
            if (!eov) begin
                chk("rnd_invariant", int'(q) * int'(dv) + int'(r), int'(dd));
                chk("rnd_rem_lt_div", (r < dv) ? 1 : 0, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
